// File: rtl/clk_div_pkg.sv
// Shared constants and helpers for the programmable clock divider.
// Provides the minimum divisor, a clamp helper and a divisor type.
package clk_div_pkg;

  localparam int unsigned CLK_DIV_MIN = 2;
  localparam int unsigned DIV_W = 8;

  typedef logic [DIV_W-1:0] div_t;

  function automatic logic [31:0] clamp_div(input logic [31:0] value);
    return (value < CLK_DIV_MIN) ? CLK_DIV_MIN : value;
  endfunction

endpackage

// File: rtl/clk_div_counter.sv
// Enable-gated wrap counter for the programmable clock divider.
// Counts 0..div-1; i_clr restarts the count regardless of enable.
module clk_div_counter
  import clk_div_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_en,
  input  logic             i_clr,
  input  logic [WIDTH-1:0] i_div,
  output logic [WIDTH-1:0] o_count,
  output logic             o_count_end,
  output logic             o_wrap
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  assign o_count     = count_q;
  assign o_count_end = (count_q == i_div - 1'b1);
  assign o_wrap      = o_count_end & i_en;

  // next count: clear, wrap to zero, increment, or hold
  always_comb begin
    count_d = count_q;
    if (i_clr) begin
      count_d = '0;
    end else if (i_en) begin
      if (o_count_end) count_d = '0;
      else             count_d = count_q + 1'b1;
    end
  end

  // count register with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

endmodule

// File: rtl/clk_divider_prog.sv
// Runtime-programmable integer clock divider with boundary-safe reload.
// Optional CLKDIV_SYNC_EN adds i_sync to restart and phase-align the divider.
module clk_divider_prog
  import clk_div_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int DEFAULT_DIV = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_div,
  input  logic             i_div_load,
`ifdef CLKDIV_SYNC_EN
  input  logic             i_sync,
`endif
  output logic [WIDTH-1:0] o_count,
  output logic             o_count_end,
  output logic             o_tick,
  output logic             o_div_clk,
  output logic [WIDTH-1:0] o_cur_div,
  output logic             o_div_pending
);

  logic [WIDTH-1:0] cur_div_q, cur_div_d;
  logic [WIDTH-1:0] pend_div_q, pend_div_d;
  logic             pend_q, pend_d;
  logic             div_clk_q, div_clk_d;

  logic             sync;
  logic             wrap;
  logic [WIDTH-1:0] load_div;
  logic [WIDTH-1:0] cnt_inc;

`ifdef CLKDIV_SYNC_EN
  assign sync = i_sync;
`else
  assign sync = 1'b0;
`endif

  assign load_div = WIDTH'(clamp_div(32'(i_div)));
  assign cnt_inc  = o_count + 1'b1;

  clk_div_counter #(
    .WIDTH(WIDTH)
  ) u_counter (
    .clk        (clk),
    .reset      (reset),
    .i_en       (i_en),
    .i_clr      (sync),
    .i_div      (cur_div_q),
    .o_count    (o_count),
    .o_count_end(o_count_end),
    .o_wrap     (wrap)
  );

  // a sync restart is not a wrap, so it never raises the tick
  assign o_tick        = wrap & ~sync;
  assign o_div_clk     = div_clk_q;
  assign o_cur_div     = cur_div_q;
  assign o_div_pending = pend_q;

  // divisor swap only at period start; waveform tracks the next count
  always_comb begin
    cur_div_d  = cur_div_q;
    pend_div_d = pend_div_q;
    pend_d     = pend_q;
    div_clk_d  = div_clk_q;
    if (i_div_load) pend_div_d = load_div;
    if (sync) begin
      div_clk_d = 1'b0;
      pend_d    = 1'b0;
      if (i_div_load)  cur_div_d = load_div;
      else if (pend_q) cur_div_d = pend_div_q;
    end else if (wrap) begin
      div_clk_d = 1'b0;
      pend_d    = 1'b0;
      if (i_div_load)  cur_div_d = load_div;
      else if (pend_q) cur_div_d = pend_div_q;
    end else begin
      if (i_en)       div_clk_d = (cnt_inc >= (cur_div_q >> 1));
      if (i_div_load) pend_d    = 1'b1;
    end
  end

  // divisor, pending and waveform registers
  always_ff @(posedge clk) begin
    if (reset) begin
      cur_div_q  <= WIDTH'(DEFAULT_DIV);
      pend_div_q <= '0;
      pend_q     <= 1'b0;
      div_clk_q  <= 1'b0;
    end else begin
      cur_div_q  <= cur_div_d;
      pend_div_q <= pend_div_d;
      pend_q     <= pend_d;
      div_clk_q  <= div_clk_d;
    end
  end

endmodule

// File: tb/tb_clk_divider_prog.sv
// Directed self-checking bench for clk_divider_prog (WIDTH=8, DEFAULT_DIV=8).
// Sync scenarios are exercised when CLKDIV_SYNC_EN is defined.
module tb_clk_divider_prog;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       i_en = 1'b1;
  logic [7:0] i_div = '0;
  logic       i_div_load = 1'b0;
  logic       i_sync = 1'b0;
  logic [7:0] o_count;
  logic       o_count_end;
  logic       o_tick;
  logic       o_div_clk;
  logic [7:0] o_cur_div;
  logic       o_div_pending;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  clk_divider_prog #(
    .WIDTH(8),
    .DEFAULT_DIV(8)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .i_en         (i_en),
    .i_div        (i_div),
    .i_div_load   (i_div_load),
`ifdef CLKDIV_SYNC_EN
    .i_sync       (i_sync),
`endif
    .o_count      (o_count),
    .o_count_end  (o_count_end),
    .o_tick       (o_tick),
    .o_div_clk    (o_div_clk),
    .o_cur_div    (o_cur_div),
    .o_div_pending(o_div_pending)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_count(input logic [7:0] v);
    int n = 0;
    while (o_count !== v && n < 64) begin
      step();
      n++;
    end
    n_cmp++;
    if (o_count !== v) begin
      n_bad++;
      $display("FAIL wait_count timeout: count=%0d required=%0d", o_count, v);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    n_cmp++; if (o_count !== 8'd0) begin n_bad++; $display("FAIL rst_count got=%0d exp=0", o_count); end
    n_cmp++; if (o_cur_div !== 8'd8) begin n_bad++; $display("FAIL rst_cur_div got=%0d exp=8", o_cur_div); end
    n_cmp++; if (o_div_clk !== 1'b0) begin n_bad++; $display("FAIL rst_div_clk got=%b exp=0", o_div_clk); end
    n_cmp++; if (o_div_pending !== 1'b0) begin n_bad++; $display("FAIL rst_pending got=%b exp=0", o_div_pending); end
    reset = 1'b0;
  endtask

  task automatic test_free_run();
    for (int i = 0; i < 20; i++) begin
      n_cmp++; if (o_count !== 8'(i % 8)) begin n_bad++; $display("FAIL run_count i=%0d got=%0d exp=%0d", i, o_count, i % 8); end
      n_cmp++; if (o_div_clk !== ((i % 8) >= 4)) begin n_bad++; $display("FAIL run_div_clk i=%0d got=%b exp=%b", i, o_div_clk, (i % 8) >= 4); end
      n_cmp++; if (o_tick !== ((i % 8) == 7)) begin n_bad++; $display("FAIL run_tick i=%0d got=%b exp=%b", i, o_tick, (i % 8) == 7); end
      step();
    end
  endtask

  task automatic test_load();
    wait_count(8'd2);
    i_div = 8'd5; i_div_load = 1'b1;
    step();
    i_div_load = 1'b0;
    n_cmp++; if (o_div_pending !== 1'b1) begin n_bad++; $display("FAIL ld_pending got=%b exp=1", o_div_pending); end
    n_cmp++; if (o_cur_div !== 8'd8) begin n_bad++; $display("FAIL ld_cur_old got=%0d exp=8", o_cur_div); end
    repeat (4) step();
    n_cmp++; if (o_tick !== 1'b1 || o_count !== 8'd7) begin n_bad++; $display("FAIL ld_wrap_tick tick=%b count=%0d exp=1/7", o_tick, o_count); end
    step();
    n_cmp++; if (o_cur_div !== 8'd5) begin n_bad++; $display("FAIL ld_cur_new got=%0d exp=5", o_cur_div); end
    n_cmp++; if (o_div_pending !== 1'b0) begin n_bad++; $display("FAIL ld_pend_clr got=%b exp=0", o_div_pending); end
    for (int j = 0; j < 5; j++) begin
      n_cmp++; if (o_count !== 8'(j)) begin n_bad++; $display("FAIL n5_count j=%0d got=%0d", j, o_count); end
      n_cmp++; if (o_div_clk !== (j >= 2)) begin n_bad++; $display("FAIL n5_div_clk j=%0d got=%b exp=%b", j, o_div_clk, j >= 2); end
      step();
    end
  endtask

  task automatic test_last_wins_and_clamp();
    i_div = 8'd3; i_div_load = 1'b1;
    step();
    i_div = 8'd6;
    step();
    i_div_load = 1'b0;
    n_cmp++; if (o_div_pending !== 1'b1 || o_cur_div !== 8'd5) begin n_bad++; $display("FAIL lw_pending pend=%b cur=%0d exp=1/5", o_div_pending, o_cur_div); end
    repeat (3) step();
    n_cmp++; if (o_cur_div !== 8'd6 || o_count !== 8'd0) begin n_bad++; $display("FAIL lw_cur cur=%0d count=%0d exp=6/0", o_cur_div, o_count); end
    for (int j = 0; j < 6; j++) begin
      n_cmp++; if (o_div_clk !== (j >= 3)) begin n_bad++; $display("FAIL n6_div_clk j=%0d got=%b exp=%b", j, o_div_clk, j >= 3); end
      step();
    end
    i_div = 8'd0; i_div_load = 1'b1;
    step();
    i_div_load = 1'b0;
    wait_count(8'd0);
    n_cmp++; if (o_cur_div !== 8'd2) begin n_bad++; $display("FAIL clamp_cur got=%0d exp=2", o_cur_div); end
    for (int j = 0; j < 4; j++) begin
      n_cmp++; if (o_count !== 8'(j % 2)) begin n_bad++; $display("FAIL n2_count j=%0d got=%0d", j, o_count); end
      n_cmp++; if (o_div_clk !== 1'(j % 2)) begin n_bad++; $display("FAIL n2_div_clk j=%0d got=%b", j, o_div_clk); end
      n_cmp++; if (o_tick !== 1'(j % 2)) begin n_bad++; $display("FAIL n2_tick j=%0d got=%b", j, o_tick); end
      step();
    end
  endtask

  task automatic test_back_to_back();
    step();
    i_div = 8'd8; i_div_load = 1'b1;
    step();
    i_div_load = 1'b0;
    n_cmp++; if (o_cur_div !== 8'd8 || o_div_pending !== 1'b0) begin n_bad++; $display("FAIL wrapload cur=%0d pend=%b exp=8/0", o_cur_div, o_div_pending); end
    n_cmp++; if (o_count !== 8'd0) begin n_bad++; $display("FAIL wrapload_count got=%0d exp=0", o_count); end
  endtask

  task automatic test_enable_hold();
    wait_count(8'd3);
    i_en = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (k == 1) begin i_div = 8'd4; i_div_load = 1'b1; end
      step();
      i_div_load = 1'b0;
      n_cmp++; if (o_count !== 8'd3 || o_div_clk !== 1'b0 || o_tick !== 1'b0) begin n_bad++; $display("FAIL hold k=%0d count=%0d clk=%b tick=%b exp=3/0/0", k, o_count, o_div_clk, o_tick); end
    end
    n_cmp++; if (o_div_pending !== 1'b1 || o_cur_div !== 8'd8) begin n_bad++; $display("FAIL hold_load pend=%b cur=%0d exp=1/8", o_div_pending, o_cur_div); end
    i_en = 1'b1;
    step();
    n_cmp++; if (o_count !== 8'd4 || o_div_clk !== 1'b1) begin n_bad++; $display("FAIL resume count=%0d clk=%b exp=4/1", o_count, o_div_clk); end
    wait_count(8'd7);
    step();
    n_cmp++; if (o_cur_div !== 8'd4 || o_div_pending !== 1'b0) begin n_bad++; $display("FAIL hold_apply cur=%0d pend=%b exp=4/0", o_cur_div, o_div_pending); end
    wait_count(8'd3);
    i_div = 8'd8; i_div_load = 1'b1;
    step();
    i_div_load = 1'b0;
    n_cmp++; if (o_cur_div !== 8'd8) begin n_bad++; $display("FAIL restore_cur got=%0d exp=8", o_cur_div); end
  endtask

  task automatic test_reset_mid();
    wait_count(8'd5);
    i_div = 8'd10; i_div_load = 1'b1;
    step();
    i_div_load = 1'b0;
    n_cmp++; if (o_count !== 8'd6 || o_div_pending !== 1'b1) begin n_bad++; $display("FAIL pre_rst count=%0d pend=%b exp=6/1", o_count, o_div_pending); end
    reset = 1'b1;
    step();
    reset = 1'b0;
    n_cmp++; if (o_count !== 8'd0 || o_cur_div !== 8'd8) begin n_bad++; $display("FAIL mid_rst count=%0d cur=%0d exp=0/8", o_count, o_cur_div); end
    n_cmp++; if (o_div_pending !== 1'b0 || o_div_clk !== 1'b0) begin n_bad++; $display("FAIL mid_rst pend=%b clk=%b exp=0/0", o_div_pending, o_div_clk); end
  endtask

`ifdef CLKDIV_SYNC_EN
  task automatic test_sync();
    wait_count(8'd2);
    i_div = 8'd4; i_div_load = 1'b1;
    step();
    i_div_load = 1'b0;
    step();
    step();
    i_sync = 1'b1;
    step();
    i_sync = 1'b0;
    n_cmp++; if (o_count !== 8'd0 || o_div_clk !== 1'b0) begin n_bad++; $display("FAIL sync count=%0d clk=%b exp=0/0", o_count, o_div_clk); end
    n_cmp++; if (o_cur_div !== 8'd4 || o_div_pending !== 1'b0) begin n_bad++; $display("FAIL sync_apply cur=%0d pend=%b exp=4/0", o_cur_div, o_div_pending); end
    wait_count(8'd3);
    i_sync = 1'b1;
    #1;
    n_cmp++; if (o_tick !== 1'b0) begin n_bad++; $display("FAIL sync_tick got=%b exp=0", o_tick); end
    step();
    i_sync = 1'b0;
    n_cmp++; if (o_count !== 8'd0) begin n_bad++; $display("FAIL sync_end count=%0d exp=0", o_count); end
    step();
    i_div = 8'd9; i_div_load = 1'b1; i_sync = 1'b1; reset = 1'b1;
    step();
    i_div_load = 1'b0; i_sync = 1'b0; reset = 1'b0;
    n_cmp++; if (o_count !== 8'd0 || o_cur_div !== 8'd8 || o_div_pending !== 1'b0) begin n_bad++; $display("FAIL sync_rst count=%0d cur=%0d pend=%b exp=0/8/0", o_count, o_cur_div, o_div_pending); end
  endtask
`endif

  initial begin
    test_reset();
    test_free_run();
    test_load();
    test_last_wins_and_clamp();
    test_back_to_back();
    test_enable_hold();
    test_reset_mid();
`ifdef CLKDIV_SYNC_EN
    test_sync();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/clk_divider_prog.md
Name: clk_divider_prog

Overview:
- Parametrised, runtime-programmable integer clock divider.
- Successor to the fixed divide-by-8 counter/divider.
- Generates a registered divided-clock enable waveform, a wrap strobe and the live count from a single `clk`.
- Adds:
  - a programmable divisor, with glitch-free updates at the period boundary;
  - a count enable;
  - odd-divisor support.
- Feeds peripheral timing and clock-enable generation.

Parameters:
- WIDTH, 8: counter and divisor width in bits.
- DEFAULT_DIV, 8: divisor loaded at reset. Legal range 2..2^WIDTH-1.

Ports:
- clk  input  1  system clock; all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- i_en  input  1  count enable. When low, all state holds.
- i_div  input  WIDTH  requested divisor N.
- i_div_load  input  1  one-cycle strobe that captures `i_div`.
- o_count  output  WIDTH  current count, 0..N-1.
- o_count_end  output  1  high when `o_count == cur_div-1`.
- o_tick  output  1  `o_count_end & i_en`, i.e. the wrap happens on this edge.
- o_div_clk  output  1  divided waveform, period N cycles.
- o_cur_div  output  WIDTH  divisor currently in effect.
- o_div_pending  output  1  a loaded divisor is waiting for the next wrap.

Behaviour:
- Reset (synchronous, dominates everything):
  - `o_count`=0, `o_div_clk`=0, `o_cur_div`=DEFAULT_DIV.
  - Pending register=0, `o_div_pending`=0.
- Divisor clamp: any captured value <2 is stored as 2. No divide-by-0 or divide-by-1 mode.
- Counter, on each posedge with `i_en`=1:
  - if `o_count == cur_div-1`, `o_count` wraps to 0;
  - otherwise `o_count` increments by 1.
- When `i_en`=0: count, `o_div_clk`, `cur_div` and pending state all hold.
- `o_div_clk`:
  - Registered and updated on the same edge as `o_count`.
  - Invariant: `o_div_clk == (o_count >= (cur_div >> 1))`.
  - Low for floor(N/2) cycles, then high for ceil(N/2) cycles.
  - Even N gives 50% duty. Odd N is high one cycle longer than low.
  - N=8: low at counts 0-3, high at counts 4-7.
- `o_count_end`: combinational from `o_count` and `cur_div`.
- `o_tick`: combinational `o_count_end & i_en`.
- Divisor update:
  - `i_div_load`=1 captures the clamped `i_div` into the pending register and sets pending.
  - A later load before the wrap overwrites the pending value; the last one wins.
  - On a wrap edge (`o_tick`=1) with pending set: `cur_div` takes the pending value, pending clears, and the new period starts at count 0 with `o_div_clk`=0.
  - Load on the same edge as a wrap: the new `i_div` is applied at that wrap directly, and pending stays 0.
  - Load while `i_en`=0: captured, then applied at the first wrap after re-enable.
- Shrinking divisor: no mid-period change is allowed, so `o_count` never exceeds `cur_div-1`.
- Reset mid-period: pending load is discarded, `cur_div` returns to DEFAULT_DIV, count returns to 0.
- Latency from `i_div_load` to the new period: the remaining cycles of the current period (at most old N).

Optional Feature:
- Macro: CLKDIV_SYNC_EN.
- Defined:
  - Adds input `i_sync` (1 bit).
  - `i_sync`=1 on a posedge, regardless of `i_en`, forces `o_count`=0 and `o_div_clk`=0.
  - Any pending divisor is applied immediately and pending clears.
  - `o_tick` is not asserted by a sync.
  - `reset` has priority over `i_sync`; `i_sync` has priority over the wrap.
  - Used to phase-align several dividers.
- Undefined: port absent, no restart capability; all other behaviour identical.

Decomposition:
- Package `clk_div_pkg` holds:
  - `CLK_DIV_MIN` = 2;
  - function `clamp_div(value)` returning max(value, CLK_DIV_MIN);
  - a divisor typedef `logic [WIDTH-1:0]` (default width).
- Sub-module `clk_div_counter` contains the enable-gated wrap counter with a `wrap` output.
- Top-level logic in `clk_divider_prog`: divisor/pending registers, `o_div_clk` and the optional sync.

Test Plan:
- Reset, `i_en`=1, 20 cycles, DEFAULT_DIV=8 → count runs 0..7 then wraps; `o_div_clk` is 0 for 4 cycles then 1 for 4; `o_tick` pulses every 8 cycles.
- Load `i_div`=5 at count 2 → `o_div_pending`=1; when the count reaches 7 it wraps; the next period is 0..4 with `o_div_clk` low for 2 cycles and high for 3; pending clears.
- Load 3 then 6 within one period → only 6 takes effect at the wrap. Load 0 → `o_cur_div`=2 and `o_div_clk` toggles every cycle.
- Hold `i_en`=0 for 5 cycles at count 3 → `o_count`=3, `o_div_clk` and `o_tick`=0 all hold; resume → count continues at 4.
- Assert `reset` at count 6 with a pending load of 10 → next cycle count=0, `o_cur_div`=8, `o_div_pending`=0.
- CLKDIV_SYNC_EN: `i_sync` at count 5 with pending 4 → next count=0, `o_cur_div`=4, `o_div_clk`=0, no `o_tick`; `i_sync` and `reset` together → reset values.
